instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_pc_reg.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 72 +++++++
 tb/tb_instruction_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch unit:
// address/instruction widths, default reset PC and NOP word, fetch FSM states.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC  = 16'h0000;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter plus the address of the word currently in flight.
// Redirect wins over stall; otherwise the PC advances unless stalled.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] inflight_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc          <= redirect_target;
      inflight_pc <= redirect_target;
    end else if (!stall) begin
      inflight_pc <= pc;
      pc          <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives instruction memory from the PC and presents
// the returned word one cycle later, squashing it after a redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_address,
  output logic               imem_stall,
  output logic               imem_kill,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid,
  output logic [15:0]        fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc, inflight_pc;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .inflight_pc     (inflight_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FLUSH;
    end else if (!stall) begin
      state_d = RUN;
    end
  end

  // A word counts as delivered only when the stage actually moves past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 16'd0;
    end else if (state_q == RUN && !stall && !redirect_valid) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

  assign if_valid       = (state_q == RUN);
  assign imem_address   = pc;
  assign imem_stall     = stall & ~redirect_valid;
  assign imem_kill      = redirect_valid;
  assign if_instruction = if_valid ? imem_instruction : NOP_INSTR;
  assign if_pc          = inflight_pc;
  assign if_pc_plus1    = inflight_pc + 16'd1;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a synchronous memory
// model returning address+0x100 and honouring imem_stall.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] imem_address;
  logic        imem_stall;
  logic        imem_kill;
  logic [15:0] imem_instruction = 16'h0000;
  logic [15:0] if_instruction;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus1;
  logic        if_valid;
  logic [15:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] NOP = 16'h7000;

  instruction_fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_address     (imem_address),
    .imem_stall       (imem_stall),
    .imem_kill        (imem_kill),
    .imem_instruction (imem_instruction),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_pc_plus1      (if_pc_plus1),
    .if_valid         (if_valid),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!imem_stall) imem_instruction <= imem_address + 16'h0100;
  end

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
    repeat (2) @(negedge clk);
    checks++; if (imem_address !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_address, 16'h0000); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    checks++; if (if_instruction !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", if_instruction, NOP); end
    checks++; if (fetch_count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", fetch_count); end
    checks++; if (if_pc !== 16'h0000) begin failures++; $display("FAIL reset_ifpc got=%h exp=0000", if_pc); end
    checks++; if (imem_kill !== 1'b0 || imem_stall !== 1'b0) begin failures++; $display("FAIL reset_imem_ctl got=%b%b exp=00", imem_kill, imem_stall); end
  endtask

  task automatic test_sequential();
    logic [15:0] e;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_address !== 16'h0000) begin failures++; $display("FAIL seq_first_addr got=%h exp=0000", imem_address); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL seq_first_valid got=%b exp=0", if_valid); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e = 16'(i);
      checks++; if (imem_address !== e) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_address, e); end
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, if_valid); end
      checks++; if (if_pc !== e - 16'd1) begin failures++; $display("FAIL seq_ifpc%0d got=%h exp=%h", i, if_pc, e - 16'd1); end
      checks++; if (if_instruction !== e + 16'h00FF) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", i, if_instruction, e + 16'h00FF); end
      checks++; if (if_pc_plus1 !== e) begin failures++; $display("FAIL seq_plus1_%0d got=%h exp=%h", i, if_pc_plus1, e); end
      checks++; if (fetch_count !== e - 16'd1) begin failures++; $display("FAIL seq_count%0d got=%h exp=%h", i, fetch_count, e - 16'd1); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (imem_stall !== 1'b1) begin failures++; $display("FAIL stall_imem got=%b exp=1", imem_stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem_address !== 16'h0005) begin failures++; $display("FAIL stall_addr%0d got=%h exp=0005", i, imem_address); end
      checks++; if (if_pc !== 16'h0004) begin failures++; $display("FAIL stall_ifpc%0d got=%h exp=0004", i, if_pc); end
      checks++; if (if_instruction !== 16'h0104) begin failures++; $display("FAIL stall_instr%0d got=%h exp=0104", i, if_instruction); end
      checks++; if (fetch_count !== 16'h0004) begin failures++; $display("FAIL stall_count%0d got=%h exp=0004", i, fetch_count); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (if_pc !== 16'h0005) begin failures++; $display("FAIL stall_release_ifpc got=%h exp=0005", if_pc); end
    checks++; if (if_instruction !== 16'h0105) begin failures++; $display("FAIL stall_release_instr got=%h exp=0105", if_instruction); end
    checks++; if (imem_address !== 16'h0006) begin failures++; $display("FAIL stall_release_addr got=%h exp=0006", imem_address); end
    checks++; if (fetch_count !== 16'h0005) begin failures++; $display("FAIL stall_release_count got=%h exp=0005", fetch_count); end
  endtask

  task automatic test_redirect();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_address !== 16'h0002) begin failures++; $display("FAIL redir_pre_addr got=%h exp=0002", imem_address); end
    redirect_valid = 1'b1; redirect_target = 16'h000A;
    #1;
    checks++; if (imem_kill !== 1'b1 || imem_stall !== 1'b0) begin failures++; $display("FAIL redir_imem_ctl got=%b%b exp=10", imem_kill, imem_stall); end
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b exp=0", if_valid); end
    checks++; if (if_instruction !== NOP) begin failures++; $display("FAIL redir_bubble_instr got=%h exp=%h", if_instruction, NOP); end
    checks++; if (imem_address !== 16'h000A) begin failures++; $display("FAIL redir_addr got=%h exp=000A", imem_address); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got=%b exp=1", if_valid); end
    checks++; if (if_pc !== 16'h000A) begin failures++; $display("FAIL redir_ifpc got=%h exp=000A", if_pc); end
    checks++; if (if_pc_plus1 !== 16'h000B) begin failures++; $display("FAIL redir_plus1 got=%h exp=000B", if_pc_plus1); end
    checks++; if (if_instruction !== 16'h010A) begin failures++; $display("FAIL redir_instr got=%h exp=010A", if_instruction); end
    checks++; if (fetch_count !== 16'h0001) begin failures++; $display("FAIL redir_count got=%h exp=0001", fetch_count); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0020;
    #1;
    checks++; if (imem_stall !== 1'b0) begin failures++; $display("FAIL sr_imem_stall got=%b exp=0", imem_stall); end
    checks++; if (imem_kill !== 1'b1) begin failures++; $display("FAIL sr_imem_kill got=%b exp=1", imem_kill); end
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_address !== 16'h0020) begin failures++; $display("FAIL sr_addr got=%h exp=0020", imem_address); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL sr_flush got=%b exp=0", if_valid); end
    @(negedge clk);
    stall = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL sr_flush_stall got=%b exp=0", if_valid); end
    checks++; if (imem_address !== 16'h0020) begin failures++; $display("FAIL sr_flush_stall_addr got=%h exp=0020", imem_address); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0020) begin failures++; $display("FAIL sr_resume got=%b/%h exp=1/0020", if_valid, if_pc); end
    checks++; if (if_instruction !== 16'h0120) begin failures++; $display("FAIL sr_resume_instr got=%h exp=0120", if_instruction); end
    checks++; if (fetch_count !== 16'h0001) begin failures++; $display("FAIL sr_count got=%h exp=0001", fetch_count); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_address !== 16'hFFFF || if_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush got=%h/%b exp=FFFF/0", imem_address, if_valid); end
    @(negedge clk);
    checks++; if (if_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_ifpc got=%h exp=FFFF", if_pc); end
    checks++; if (if_pc_plus1 !== 16'h0000) begin failures++; $display("FAIL wrap_plus1 got=%h exp=0000", if_pc_plus1); end
    checks++; if (imem_address !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h exp=0000", imem_address); end
    checks++; if (if_instruction !== 16'h00FF) begin failures++; $display("FAIL wrap_instr got=%h exp=00FF", if_instruction); end
    @(negedge clk);
    checks++; if (if_pc !== 16'h0000 || if_instruction !== 16'h0100) begin failures++; $display("FAIL wrap_next got=%h/%h exp=0000/0100", if_pc, if_instruction); end
    checks++; if (fetch_count !== 16'h0002) begin failures++; $display("FAIL wrap_count_pre got=%h exp=0002", fetch_count); end
    repeat (16'hFFFD) @(negedge clk);
    checks++; if (fetch_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_count_max got=%h exp=FFFF", fetch_count); end
    @(negedge clk);
    checks++; if (fetch_count !== 16'h0000) begin failures++; $display("FAIL wrap_count_zero got=%h exp=0000", fetch_count); end
  endtask

  task automatic test_midrun_reset();
    redirect_valid = 1'b1; redirect_target = 16'h0033;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", if_valid); end
    checks++; if (imem_address !== 16'h0000) begin failures++; $display("FAIL mrst_addr got=%h exp=0000", imem_address); end
    checks++; if (fetch_count !== 16'h0000) begin failures++; $display("FAIL mrst_count got=%h exp=0000", fetch_count); end
    checks++; if (if_instruction !== NOP || if_pc !== 16'h0000) begin failures++; $display("FAIL mrst_if got=%h/%h exp=%h/0000", if_instruction, if_pc, NOP); end
    redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_address !== 16'h0000) begin failures++; $display("FAIL mrst_release_addr got=%h exp=0000", imem_address); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || imem_address !== 16'h0001) begin failures++; $display("FAIL mrst_resume got=%b/%h/%h exp=1/0000/0001", if_valid, if_pc, imem_address); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
